qam_demodulator: RTL and testbench

QAM_DEMODULATOR -- requirements
Module: qam_demodulator

---
 rtl/qam_demodulator.sv | 240 ++++++++++++++++++++++++
 tb/tb_qam_demodulator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_demodulator.sv
// 16-QAM coherent demodulator: per-symbol I/Q correlation against a 16-entry sine LUT, then 4-level slicing.
// Optional serial bit output is built when QAM_DEMOD_SERIAL_OUT_EN is defined.
module qam_demodulator #(
    parameter int unsigned        SPS       = 16,
    parameter logic signed [23:0] SLICE_THR = 24'sd1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [9:0] sample,
    input  logic              sample_valid,
    input  logic              sym_start,
    output logic [1:0]        SigI,
    output logic [1:0]        SigQ,
    output logic              sym_valid,
    output logic              sync_err
`ifdef QAM_DEMOD_SERIAL_OUT_EN
    ,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              overrun
`endif
);

    localparam int unsigned SAMP_W = 10;
    localparam int unsigned PROD_W = 20;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned IDX_W  = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DUMP  = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPS - 1);

    // round(511*sin(2*pi*k/16))
    function automatic logic signed [SAMP_W-1:0] sin_lut(input logic [IDX_W-1:0] k);
        case (k)
            4'd0:    return 10'sd0;
            4'd1:    return 10'sd196;
            4'd2:    return 10'sd361;
            4'd3:    return 10'sd472;
            4'd4:    return 10'sd511;
            4'd5:    return 10'sd472;
            4'd6:    return 10'sd361;
            4'd7:    return 10'sd196;
            4'd8:    return 10'sd0;
            4'd9:    return -10'sd196;
            4'd10:   return -10'sd361;
            4'd11:   return -10'sd472;
            4'd12:   return -10'sd511;
            4'd13:   return -10'sd472;
            4'd14:   return -10'sd361;
            default: return -10'sd196;
        endcase
    endfunction

    // Gray-coded 4-level decision: 00 < 01 < 0 <= 11 < 10
    function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] a);
        if (a < -SLICE_THR)      return 2'b00;
        else if (a < 24'sd0)     return 2'b01;
        else if (a < SLICE_THR)  return 2'b11;
        else                     return 2'b10;
    endfunction

    logic [1:0]               r_state;
    logic [IDX_W-1:0]         r_idx;
    logic signed [ACC_W-1:0]  r_acc_i;
    logic signed [ACC_W-1:0]  r_acc_q;
    logic [1:0]               r_sig_i;
    logic [1:0]               r_sig_q;
    logic                     r_sym_valid;
    logic                     r_sync_err;

    logic [1:0]               w_state_nxt;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic signed [ACC_W-1:0]  w_acc_i_nxt;
    logic signed [ACC_W-1:0]  w_acc_q_nxt;
    logic [1:0]               w_sig_i_nxt;
    logic [1:0]               w_sig_q_nxt;
    logic                     w_sym_valid_nxt;
    logic                     w_sync_err_nxt;

    logic                     w_sof;
    logic [IDX_W-1:0]         w_idx_sel;
    logic signed [SAMP_W-1:0] w_cos;
    logic signed [SAMP_W-1:0] w_sin;
    logic signed [PROD_W-1:0] w_prod_i;
    logic signed [PROD_W-1:0] w_prod_q;
    logic signed [ACC_W-1:0]  w_prod_i_ext;
    logic signed [ACC_W-1:0]  w_prod_q_ext;
    logic [1:0]               w_slice_i;
    logic [1:0]               w_slice_q;

    // Any symbol start (from IDLE, DUMP or an ACCUM restart) correlates at index 0
    assign w_sof        = sample_valid & sym_start;
    assign w_idx_sel    = (r_state == S_ACCUM && !sym_start) ? r_idx : '0;
    assign w_sin        = sin_lut(w_idx_sel);
    assign w_cos        = sin_lut(w_idx_sel + IDX_W'(4));
    assign w_prod_i     = PROD_W'(sample) * PROD_W'(w_cos);
    assign w_prod_q     = PROD_W'(sample) * PROD_W'(w_sin);
    assign w_prod_i_ext = ACC_W'(w_prod_i);
    assign w_prod_q_ext = ACC_W'(w_prod_q);
    assign w_slice_i    = slice(r_acc_i);
    assign w_slice_q    = slice(r_acc_q);

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_acc_i_nxt     = r_acc_i;
        w_acc_q_nxt     = r_acc_q;
        w_sig_i_nxt     = r_sig_i;
        w_sig_q_nxt     = r_sig_q;
        w_sym_valid_nxt = 1'b0;
        w_sync_err_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sof) begin
                    w_acc_i_nxt = w_prod_i_ext;
                    w_acc_q_nxt = w_prod_q_ext;
                    w_idx_nxt   = IDX_W'(1);
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sample_valid) begin
                    if (sym_start && r_idx != '0) begin
                        w_sync_err_nxt = 1'b1;
                        w_acc_i_nxt    = w_prod_i_ext;
                        w_acc_q_nxt    = w_prod_q_ext;
                        w_idx_nxt      = IDX_W'(1);
                    end else begin
                        w_acc_i_nxt = r_acc_i + w_prod_i_ext;
                        w_acc_q_nxt = r_acc_q + w_prod_q_ext;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = S_DUMP;
                        end
                    end
                end
            end
            S_DUMP: begin
                w_sig_i_nxt     = w_slice_i;
                w_sig_q_nxt     = w_slice_q;
                w_sym_valid_nxt = 1'b1;
                if (w_sof) begin
                    w_acc_i_nxt = w_prod_i_ext;
                    w_acc_q_nxt = w_prod_q_ext;
                    w_idx_nxt   = IDX_W'(1);
                    w_state_nxt = S_ACCUM;
                end else begin
                    w_sync_err_nxt = sample_valid;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_sig_i     <= 2'b00;
            r_sig_q     <= 2'b00;
            r_sym_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_acc_i     <= w_acc_i_nxt;
            r_acc_q     <= w_acc_q_nxt;
            r_sig_i     <= w_sig_i_nxt;
            r_sig_q     <= w_sig_q_nxt;
            r_sym_valid <= w_sym_valid_nxt;
            r_sync_err  <= w_sync_err_nxt;
        end
    end

    assign SigI      = r_sig_i;
    assign SigQ      = r_sig_q;
    assign sym_valid = r_sym_valid;
    assign sync_err  = r_sync_err;

`ifdef QAM_DEMOD_SERIAL_OUT_EN
    logic [3:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_bit_valid;
    logic       r_overrun;
    logic [3:0] w_shift_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic       w_overrun_nxt;
    logic       w_xfer;
    logic       w_remain;

    // A symbol arriving on the final bit's transfer cycle is not an overrun
    assign w_xfer   = r_bit_valid & bit_ready;
    assign w_remain = r_bit_valid & !(w_xfer && r_bit_cnt == 3'd1);

    always_comb begin
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_overrun_nxt = 1'b0;
        if (w_xfer) begin
            w_shift_nxt   = {r_shift[2:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
        end
        if (r_state == S_DUMP) begin
            if (w_remain) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_shift_nxt   = {w_slice_i, w_slice_q};
                w_bit_cnt_nxt = 3'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_bit_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_bit_valid <= (w_bit_cnt_nxt != 3'd0);
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign bit_out   = r_shift[3];
    assign bit_valid = r_bit_valid;
    assign overrun   = r_overrun;
`endif

endmodule

// File: tb/tb_qam_demodulator.sv
// Directed bench for qam_demodulator; serial-output scenario compiled when QAM_DEMOD_SERIAL_OUT_EN is defined.
module tb_qam_demodulator;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [9:0] sample;
    logic              sample_valid;
    logic              sym_start;
    logic [1:0]        SigI;
    logic [1:0]        SigQ;
    logic              sym_valid;
    logic              sync_err;
`ifdef QAM_DEMOD_SERIAL_OUT_EN
    logic              bit_out;
    logic              bit_valid;
    logic              bit_ready;
    logic              overrun;
`endif

    int n_vec = 0;
    int n_err = 0;
    int sin_tab [16] = '{0, 196, 361, 472, 511, 472, 361, 196,
                         0, -196, -361, -472, -511, -472, -361, -196};

    qam_demodulator dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .SigI         (SigI),
        .SigQ         (SigQ),
        .sym_valid    (sym_valid),
        .sync_err     (sync_err)
`ifdef QAM_DEMOD_SERIAL_OUT_EN
        ,
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .overrun      (overrun)
`endif
    );

    always #5 clk = ~clk;

    // Modulated sample a*cos + b*sin, scaled by 1/5 so (-3,-3) fits in 10 bits
    function automatic logic signed [9:0] samp(input int a, input int b, input int k);
        int v;
        v = (a * sin_tab[(k + 4) % 16] + b * sin_tab[k % 16]) / 5;
        return 10'(v);
    endfunction

    task automatic drive(input logic v, input logic st, input logic signed [9:0] s);
        sample_valid = v;
        sym_start    = st;
        sample       = s;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b0, 1'b0, 10'sd0);
        repeat (2) @(negedge clk);
        n_vec++;
        if ({SigI, SigQ, sym_valid, sync_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_values got %b exp 000000", {SigI, SigQ, sym_valid, sync_err});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            n_vec++;
            if (sym_valid !== (n == 17) || sync_err !== 1'b0) begin
                n_err++;
                $display("FAIL single_pulse n=%0d got sv=%b se=%b exp sv=%b se=0", n, sym_valid, sync_err, n == 17);
            end
            if (n == 17) begin
                n_vec++;
                if ({SigI, SigQ} !== 4'b1001) begin
                    n_err++;
                    $display("FAIL single_sym got %b exp 1001", {SigI, SigQ});
                end
            end
            if (n < 16) drive(1'b1, n == 0, samp(3, -1, n));
            else        drive(1'b0, 1'b0, 10'sd0);
        end
    endtask

    task automatic test_gapped;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            n_vec++;
            if (sym_valid !== (n == 32) || sync_err !== 1'b0) begin
                n_err++;
                $display("FAIL gapped_pulse n=%0d got sv=%b se=%b exp sv=%b se=0", n, sym_valid, sync_err, n == 32);
            end
            if (n == 32) begin
                n_vec++;
                if ({SigI, SigQ} !== 4'b1001) begin
                    n_err++;
                    $display("FAIL gapped_sym got %b exp 1001", {SigI, SigQ});
                end
            end
            if (n < 32 && n % 2 == 0) drive(1'b1, n == 0, samp(3, -1, n / 2));
            else                      drive(1'b0, 1'b0, 10'sd0);
        end
    endtask

    task automatic test_sync_abort;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            n_vec++;
            if (sym_valid !== (n == 25) || sync_err !== (n == 9)) begin
                n_err++;
                $display("FAIL abort_pulse n=%0d got sv=%b se=%b exp sv=%b se=%b",
                         n, sym_valid, sync_err, n == 25, n == 9);
            end
            if (n == 25) begin
                n_vec++;
                if ({SigI, SigQ} !== 4'b0110) begin
                    n_err++;
                    $display("FAIL abort_sym got %b exp 0110", {SigI, SigQ});
                end
            end
            if (n < 8)       drive(1'b1, n == 0, samp(1, 1, n));
            else if (n < 24) drive(1'b1, n == 8, samp(-1, 3, n - 8));
            else             drive(1'b0, 1'b0, 10'sd0);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            n_vec++;
            if (sym_valid !== (n == 17 || n == 33) || sync_err !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_pulse n=%0d got sv=%b se=%b exp sv=%b se=0",
                         n, sym_valid, sync_err, n == 17 || n == 33);
            end
            if (n == 17 || n == 33) begin
                n_vec++;
                if ({SigI, SigQ} !== ((n == 17) ? 4'b1111 : 4'b0000)) begin
                    n_err++;
                    $display("FAIL b2b_sym n=%0d got %b exp %b", n, {SigI, SigQ}, (n == 17) ? 4'b1111 : 4'b0000);
                end
            end
            if (n < 16)      drive(1'b1, n == 0, samp(1, 1, n));
            else if (n < 32) drive(1'b1, n == 16, samp(-3, -3, n - 16));
            else             drive(1'b0, 1'b0, 10'sd0);
        end
    endtask

    task automatic test_dump_err;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            n_vec++;
            if (sym_valid !== (n == 17) || sync_err !== (n == 17)) begin
                n_err++;
                $display("FAIL dumperr_pulse n=%0d got sv=%b se=%b exp sv=%b se=%b",
                         n, sym_valid, sync_err, n == 17, n == 17);
            end
            if (n == 17) begin
                n_vec++;
                if ({SigI, SigQ} !== 4'b1010) begin
                    n_err++;
                    $display("FAIL dumperr_sym got %b exp 1010", {SigI, SigQ});
                end
            end
            if (n < 16)      drive(1'b1, n == 0, samp(3, 3, n));
            else if (n < 22) drive(1'b1, 1'b0, samp(3, 3, n - 16));
            else             drive(1'b0, 1'b0, 10'sd0);
        end
    endtask

    task automatic test_reset_mid;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            drive(1'b1, n == 0, samp(-3, -3, n));
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({SigI, SigQ, sym_valid, sync_err} !== 6'b0) begin
            n_err++;
            $display("FAIL midreset_values got %b exp 000000", {SigI, SigQ, sym_valid, sync_err});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 24; n++) begin
            drive(1'b1, 1'b0, samp(-3, -3, (n + 10) % 16));
            @(negedge clk);
            n_vec++;
            if (sym_valid !== 1'b0 || sync_err !== 1'b0 || {SigI, SigQ} !== 4'b0000) begin
                n_err++;
                $display("FAIL midreset_idle n=%0d got sv=%b se=%b sym=%b exp 0 0 0000",
                         n, sym_valid, sync_err, {SigI, SigQ});
            end
        end
        drive(1'b0, 1'b0, 10'sd0);
    endtask

`ifdef QAM_DEMOD_SERIAL_OUT_EN
    task automatic test_serial;
        logic [3:0] exp_bits;
        exp_bits  = 4'b1001;
        bit_ready = 1'b0;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            n_vec++;
            if (sym_valid !== (n == 17 || n == 33) || overrun !== (n == 33)) begin
                n_err++;
                $display("FAIL serial_pulse n=%0d got sv=%b ov=%b exp sv=%b ov=%b",
                         n, sym_valid, overrun, n == 17 || n == 33, n == 33);
            end
            n_vec++;
            if (bit_valid !== (n >= 17) || (n >= 17 && bit_out !== 1'b1)) begin
                n_err++;
                $display("FAIL serial_hold n=%0d got bv=%b bo=%b exp bv=%b bo=1", n, bit_valid, bit_out, n >= 17);
            end
            if (n < 16)      drive(1'b1, n == 0, samp(3, -1, n));
            else if (n < 32) drive(1'b1, n == 16, samp(-3, -3, n - 16));
            else             drive(1'b0, 1'b0, 10'sd0);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bit_valid !== 1'b1 || bit_out !== exp_bits[3 - i]) begin
                n_err++;
                $display("FAIL serial_bit i=%0d got bv=%b bo=%b exp bv=1 bo=%b", i, bit_valid, bit_out, exp_bits[3 - i]);
            end
            bit_ready = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (bit_valid !== 1'b0) begin
            n_err++;
            $display("FAIL serial_empty got bv=%b exp 0", bit_valid);
        end
        bit_ready = 1'b0;
    endtask
`endif

    initial begin
`ifdef QAM_DEMOD_SERIAL_OUT_EN
        bit_ready = 1'b0;
`endif
        test_reset;
        test_single;
        test_gapped;
        test_sync_abort;
        test_back_to_back;
        test_dump_err;
        test_reset_mid;
`ifdef QAM_DEMOD_SERIAL_OUT_EN
        test_serial;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
